// File: rtl/encoder_83_pkg.sv
// Shared constants and index type for the 8-to-3 priority encoder and the
// logic that consumes its binary index.
package encoder_83_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : encoder_83_pkg

// File: rtl/encoder_83_core.sv
// Combinational core: MSB-priority index, any-set flag and a multi-hot flag
// built from a pairwise-OR reduction tree.
module encoder_83_core
  import encoder_83_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic [IN_W-1:0]  i,
  output logic [OUT_W-1:0] y_c,
  output logic             valid_c,
  output logic             multi_c
);

  // Ascending scan so the last hit, the most-significant set bit, wins.
  always_comb begin : prio_enc
    y_c = '0;
    for (int k = 0; k < IN_W; k++) begin
      if (i[k]) y_c = OUT_W'(k);
    end
  end

  assign valid_c = |i;

  // Each tree level folds pairs of (any, multi) nodes in place; a pair is
  // multi-hot if either half already was or both halves have a set bit.
  always_comb begin : multi_tree
    logic [IN_W-1:0] any_v;
    logic [IN_W-1:0] mul_v;
    any_v = i;
    mul_v = '0;
    for (int l = 1; l <= OUT_W; l++) begin
      for (int k = 0; k < IN_W / 2; k++) begin
        if (k < (IN_W >> l)) begin
          mul_v[k] = mul_v[2*k] | mul_v[2*k+1] | (any_v[2*k] & any_v[2*k+1]);
          any_v[k] = any_v[2*k] | any_v[2*k+1];
        end
      end
    end
    multi_c = mul_v[0];
  end

endmodule : encoder_83_core

// File: rtl/encoder_83.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags;
// one cycle of latency, accepts a new input every cycle.
module encoder_83
  import encoder_83_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  if (IN_W < 2 || OUT_W != $clog2(IN_W) || (1 << OUT_W) != IN_W) begin : g_param_chk
    $error("encoder_83: IN_W must be a power of 2 >= 2 and OUT_W == $clog2(IN_W)");
  end

  logic [OUT_W-1:0] y_p0;
  logic             vld_p0;
  logic             multi_p0;

  encoder_83_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i       (i),
    .y_c     (y_p0),
    .valid_c (vld_p0),
    .multi_c (multi_p0)
  );

  logic [OUT_W-1:0] y_p1;
  logic             vld_p1;
  logic             multi_p1;

  // Stage p0 -> p1: output registers; all cleared on reset so y reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p1     <= '0;
      vld_p1   <= 1'b0;
      multi_p1 <= 1'b0;
    end else begin
      y_p1     <= y_p0;
      vld_p1   <= vld_p0;
      multi_p1 <= multi_p0;
    end
  end

  assign y     = y_p1;
  assign valid = vld_p1;
  assign multi = multi_p1;

endmodule : encoder_83

// File: tb/tb_encoder_83.sv
// Scoreboard bench for encoder_83: expected outputs are queued as each input
// is applied and compared one clock edge later.
module tb_encoder_83;
  import encoder_83_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic [7:0] i;
  enc_idx_t y;
  logic     valid;
  logic     multi;

  always #5 clk = ~clk;

  encoder_83 dut (
    .clk   (clk),
    .rst   (rst),
    .i     (i),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  typedef struct packed {
    logic [2:0] y;
    logic       valid;
    logic       multi;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int yy, input logic v, input logic m);
    exp_t e;
    e.y     = 3'(yy);
    e.valid = v;
    e.multi = m;
    return e;
  endfunction

  // Reference: MSB index found top-down, OR-reduce, popcount >= 2.
  function automatic exp_t model(input logic [7:0] v);
    exp_t e;
    e = mk(0, 1'b0, 1'b0);
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) begin
        e.y = 3'(k);
        break;
      end
    end
    e.valid = (v != 8'h00);
    e.multi = ($countones(v) >= 2);
    return e;
  endfunction

  task automatic step(input string tag, input logic [7:0] v, input logic r, input exp_t e);
    exp_t got;
    i   = v;
    rst = r;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_y"},     {5'b0, y},     {5'b0, got.y});
      chk({tag, "_valid"}, {7'b0, valid}, {7'b0, got.valid});
      chk({tag, "_multi"}, {7'b0, multi}, {7'b0, got.multi});
    end
  endtask

  initial begin
    rst = 1'b1;
    i   = 8'hFF;
    @(negedge clk);

    for (int c = 0; c < 2; c++) step("reset", 8'hFF, 1'b1, mk(0, 1'b0, 1'b0));

    for (int c = 0; c < 3; c++) step("zero", 8'h00, 1'b0, mk(0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) step("onehot", 8'(1 << k), 1'b0, mk(k, 1'b1, 1'b0));
    end

    step("multi06", 8'h06, 1'b0, mk(2, 1'b1, 1'b1));
    step("multi81", 8'h81, 1'b0, mk(7, 1'b1, 1'b1));
    step("multiFF", 8'hFF, 1'b0, mk(7, 1'b1, 1'b1));
    step("multi26", 8'h26, 1'b0, mk(5, 1'b1, 1'b1));

    step("b2b_10", 8'h10, 1'b0, mk(4, 1'b1, 1'b0));
    step("b2b_00", 8'h00, 1'b0, mk(0, 1'b0, 1'b0));
    step("b2b_40", 8'h40, 1'b0, mk(6, 1'b1, 1'b0));

    step("mid_pre",  8'h20, 1'b0, mk(5, 1'b1, 1'b0));
    step("mid_pre",  8'h20, 1'b0, mk(5, 1'b1, 1'b0));
    step("mid_rst",  8'h20, 1'b1, mk(0, 1'b0, 1'b0));
    step("mid_post", 8'h20, 1'b0, mk(5, 1'b1, 1'b0));

    for (int v = 0; v < 256; v++) step("sweep", 8'(v), 1'b0, model(8'(v)));

    for (int n = 0; n < 200; n++) begin
      logic [7:0] rv;
      logic       rr;
      rv = 8'($urandom_range(0, 255));
      rr = ($urandom_range(0, 15) == 0);
      step("rand", rv, rr, rr ? mk(0, 1'b0, 1'b0) : model(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_encoder_83
